// File: rtl/sc_gate_and_arbiter.sv
// sc_gate_and_arbiter
//
// Round-robin controller that time-shares one registered bitwise AND unit among
// up to NUM_REQ requesters. A transaction walks IDLE -> LOAD -> EXEC -> RESP:
// the winner is chosen in IDLE, granted and its operands captured in LOAD, the
// AND is registered in EXEC and the result is presented in RESP until the
// winner acknowledges it.
//
// Optional feature: define SC_GATE_AND_ARBITER_TIMEOUT_EN to bound the RESP
// wait to TIMEOUT_CYCLES cycles. On expiry the result is dropped and err_Out
// pulses for one cycle. With the macro undefined err_Out is constant 0 and
// TIMEOUT_CYCLES has no effect.
//
// All outputs are decoded from registered state only; there are no
// combinational input-to-output paths.

module sc_gate_and_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ID_WIDTH       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             CLOCK_50,
  input  logic                             RESET_InHigh,
  input  logic [NUM_REQ-1:0]               req_In,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    a_In,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    b_In,
  input  logic [NUM_REQ-1:0]               ack_In,
  output logic [NUM_REQ-1:0]               grant_Out,
  output logic                             valid_Out,
  output logic [DATA_WIDTH-1:0]            z_Out,
  output logic [ID_WIDTH-1:0]              id_Out,
  output logic                             busy_Out,
  output logic                             err_Out
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StExec = 2'd2,
    StResp = 2'd3
  } state_e;

  state_e                  state_q, state_d;

  // ptr_q holds the most recently granted requester; search starts just past it.
  logic [ID_WIDTH-1:0]     ptr_q;
  logic [ID_WIDTH-1:0]     winner_q;
  logic [DATA_WIDTH-1:0]   op_a_q;
  logic [DATA_WIDTH-1:0]   op_b_q;
  logic [DATA_WIDTH-1:0]   z_q;

  logic                    pick_valid;
  logic [ID_WIDTH-1:0]     pick_idx;
  logic [ID_WIDTH-1:0]     cand_idx;
  int unsigned             cand;

  logic [DATA_WIDTH-1:0]   sel_a;
  logic [DATA_WIDTH-1:0]   sel_b;
  logic                    winner_ack;
  logic                    timeout;

  // Acknowledge from the current owner only; other ack bits are ignored.
  assign winner_ack = ack_In[winner_q];

  // Round-robin pick: first set request at ptr+1, ptr+2, ... modulo NUM_REQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand     = (32'(ptr_q) + k) % NUM_REQ;
      cand_idx = ID_WIDTH'(cand);
      if (!pick_valid && req_In[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Operand slice mux for the latched winner, built from constant slices.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner_q == ID_WIDTH'(i)) begin
        sel_a = a_In[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b = b_In[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef SC_GATE_AND_ARBITER_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntWidth-1:0] cnt_q;
  logic                err_q;

  // Expires on the last RESP cycle of the window; a same-cycle ack still wins.
  assign timeout = (state_q == StResp) && !winner_ack &&
                   (cnt_q == CntWidth'(TIMEOUT_CYCLES - 1));

  // Count cycles spent in RESP and register the one-cycle error pulse.
  always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
    if (RESET_InHigh) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
      if (state_q == StResp) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign err_Out = err_q;
`else
  assign timeout = 1'b0;
  assign err_Out = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
    if (RESET_InHigh) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests only matter in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StLoad;
        end
      end
      StLoad: state_d = StExec;
      StExec: state_d = StResp;
      StResp: begin
        if (winner_ack || timeout) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Arbitration bookkeeping and the registered AND datapath.
  always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
    if (RESET_InHigh) begin
      ptr_q    <= ID_WIDTH'(NUM_REQ - 1);
      winner_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      z_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            winner_q <= pick_idx;
            ptr_q    <= pick_idx;
          end
        end
        StLoad: begin
          op_a_q <= sel_a;
          op_b_q <= sel_b;
        end
        StExec: begin
          z_q <= op_a_q & op_b_q;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state; result fields read 0 outside RESP.
  always_comb begin
    grant_Out = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant_Out[i] = (state_q == StLoad) && (winner_q == ID_WIDTH'(i));
    end
    valid_Out = (state_q == StResp);
    busy_Out  = (state_q != StIdle);
    z_Out     = valid_Out ? z_q : '0;
    id_Out    = valid_Out ? winner_q : '0;
  end

endmodule
